// File: rtl/fifo_pkg.sv
// Shared types for the synchronous FIFO: default address width, pointer/count types, op encoding.
// Pure declarations; no logic, no latency, no backpressure.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 2;

    typedef logic [FIFO_ADDR_WIDTH-1:0] ptr_t;
    typedef logic [FIFO_ADDR_WIDTH:0]   cnt_t;

    // Encoded as {push_accepted, pop_accepted} so the accept strobes map straight onto it.
    typedef enum logic [1:0] {
        NOP  = 2'b00,
        PUSH = 2'b10,
        POP  = 2'b01,
        BOTH = 2'b11
    } op_t;

endpackage

// File: rtl/fifo_ctrl.sv
// FIFO pointer/status controller; sticky overflow/underflow ports exist only with FIFO_CTRL_ERR_EN.
// Latency: wr_en/rd_ack combinational; pointers, count and flags update on the accepting edge.
// Backpressure: push refused when full unless a pop lands the same cycle; pop refused when empty.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_LEVEL   = 3,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  wr_en,
    output logic                  rd_ack,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
`ifdef FIFO_CTRL_ERR_EN
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [ADDR_WIDTH:0]   count
);

    localparam int                DEPTH_I = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH  = DEPTH_I[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_CNT = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_CNT = AE_LEVEL[ADDR_WIDTH:0];

    op_t                 op;
    logic [ADDR_WIDTH:0] count_nxt;

    assign rd_ack = rd & ~empty;
    assign wr_en  = wr & (~full | rd_ack);
    assign op     = op_t'({wr_en, rd_ack});

    always_comb begin
        count_nxt = count;
        case (op)
            PUSH:    count_nxt = count + 1'b1;
            POP:     count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Flags come from count_nxt so they move on the same edge as count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_addr      <= '0;
            rd_addr      <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_addr <= wr_addr + 1'b1;
            end
            if (rd_ack) begin
                rd_addr <= rd_addr + 1'b1;
            end
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_CNT);
            almost_empty <= (count_nxt <= AE_CNT);
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr & full & ~rd_ack) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd & empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed boundary sequences then biased random push/pop against an occupancy model.
// Model tracks totals pushed/popped; pointers are those totals modulo depth.
module tb_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clk;
    logic          reset_n;
    logic          wr;
    logic          rd;
    logic          err_clr;
    logic          wr_en;
    logic          rd_ack;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
`ifdef FIFO_CTRL_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int m_cnt    = 0;
    int m_pushes = 0;
    int m_pops   = 0;
    bit m_ovf    = 0;
    bit m_udf    = 0;

    fifo_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr          (wr),
        .rd          (rd),
        .wr_en       (wr_en),
        .rd_ack      (rd_ack),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
`ifdef FIFO_CTRL_ERR_EN
        .err_clr     (err_clr),
        .overflow    (overflow),
        .underflow   (underflow),
`endif
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_pushes = 0;
        m_pops   = 0;
        m_ovf    = 0;
        m_udf    = 0;
    endtask

    task automatic check_state();
        chk("count",        int'(count),        m_cnt);
        chk("wr_addr",      int'(wr_addr),      m_pushes % DEPTH);
        chk("rd_addr",      int'(rd_addr),      m_pops % DEPTH);
        chk("full",         int'(full),         int'(m_cnt == DEPTH));
        chk("empty",        int'(empty),        int'(m_cnt == 0));
        chk("almost_full",  int'(almost_full),  int'(m_cnt >= AF));
        chk("almost_empty", int'(almost_empty), int'(m_cnt <= AE));
`ifdef FIFO_CTRL_ERR_EN
        chk("overflow",     int'(overflow),     int'(m_ovf));
        chk("underflow",    int'(underflow),    int'(m_udf));
`endif
    endtask

    // One clock of stimulus: drive at negedge, check strobes, then check state after the edge.
    task automatic step(input logic w, input logic r, input logic c);
        bit exp_ack;
        bit exp_wen;
        bit set_ovf;
        bit set_udf;
        @(negedge clk);
        wr      = w;
        rd      = r;
        err_clr = c;
        #1;
        exp_ack = r && (m_cnt > 0);
        exp_wen = w && ((m_cnt < DEPTH) || exp_ack);
        chk("rd_ack", int'(rd_ack), int'(exp_ack));
        chk("wr_en",  int'(wr_en),  int'(exp_wen));
        set_ovf = w && (m_cnt == DEPTH) && !exp_ack;
        set_udf = r && (m_cnt == 0);
        @(posedge clk);
        if (exp_wen) begin
            m_cnt++;
            m_pushes++;
        end
        if (exp_ack) begin
            m_cnt--;
            m_pops++;
        end
        m_ovf = set_ovf ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_udf = set_udf ? 1'b1 : (c ? 1'b0 : m_udf);
        #1;
        check_state();
    endtask

    initial begin
        wr      = 1'b0;
        rd      = 1'b0;
        err_clr = 1'b0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_state();
        @(negedge clk);
        reset_n = 1'b1;

        // Fill to full, then push with no pop (refused), then clear errors.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Push+pop at full: both accepted.
        step(1'b1, 1'b1, 1'b0);

        // Drain, then one extra pop while empty, then clear.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Push+pop at empty: only the push; then reach 2 and do push+pop.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0);

        // Wrap stress: alternating push/pop pairs.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0);
            chk("wrap_ptr_eq", int'(rd_addr), int'(wr_addr));
        end

        // Asynchronous reset mid-fill, away from any clock edge.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_state();
        @(negedge clk);
        wr      = 1'b0;
        rd      = 1'b0;
        reset_n = 1'b1;

        // Random phases with varying push/pop bias to visit full and empty repeatedly.
        for (int ph = 0; ph < 4; ph++) begin
            int wp;
            int rp;
            wp = (ph % 2 == 0) ? 75 : 30;
            rp = (ph % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 100; i++) begin
                step(logic'($urandom_range(99) < wp),
                     logic'($urandom_range(99) < rp),
                     logic'($urandom_range(99) < 10));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
